// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter: one word of WIDTH bits out one bit per cycle, first bit 1 cycle after accept.
// Backpressure: data_ready only in IDLE or on the last bit, so back-to-back words stream without gaps.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_sof,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] sr_q;
  logic             out_bit_q;
  logic             out_valid_q;
  logic             out_sof_q;

  logic             last_bit;
  logic             transfer;
  logic             load_bit_d;
  logic             next_bit_d;
  logic [WIDTH-1:0] sr_shift_d;

  assign last_bit   = (bit_cnt_q == LAST_CNT);
  assign data_ready = !rst && ((state_q == IDLE) || last_bit);
  assign transfer   = data_valid && data_ready;

  // sr_q keeps the word with the bit currently on out_bit at the leading end.
  always_comb begin
    load_bit_d = 1'b0;
    next_bit_d = 1'b0;
    sr_shift_d = '0;
    if (MSB_FIRST) begin
      load_bit_d = data_in[WIDTH-1];
      next_bit_d = sr_q[WIDTH-2];
      sr_shift_d = {sr_q[WIDTH-2:0], 1'b0};
    end else begin
      load_bit_d = data_in[0];
      next_bit_d = sr_q[1];
      sr_shift_d = {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (transfer) begin
            state_q     <= SHIFT;
            sr_q        <= data_in;
            bit_cnt_q   <= '0;
            out_bit_q   <= load_bit_d;
            out_valid_q <= 1'b1;
            out_sof_q   <= 1'b1;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            sr_q      <= sr_shift_d;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            out_bit_q <= next_bit_d;
            out_sof_q <= 1'b0;
          end else if (transfer) begin
            sr_q        <= data_in;
            bit_cnt_q   <= '0;
            out_bit_q   <= load_bit_d;
            out_valid_q <= 1'b1;
            out_sof_q   <= 1'b1;
          end else begin
            state_q     <= IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          bit_cnt_q   <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign busy      = out_valid_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: directed word scenarios plus a randomized run against a word-queue model.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;

  logic m_data_ready, m_out_bit, m_out_valid, m_out_sof, m_busy;
  logic l_data_ready, l_out_bit, l_out_valid, l_out_sof, l_busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(m_data_ready), .out_bit(m_out_bit), .out_valid(m_out_valid),
    .out_sof(m_out_sof), .busy(m_busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(l_data_ready), .out_bit(l_out_bit), .out_valid(l_out_valid),
    .out_sof(l_out_sof), .busy(l_busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; data_valid = 1'b1; data_in = 8'hA5;
    cyc(); cyc();
    n_total++; if ({m_out_valid, m_out_bit, m_out_sof, m_busy} !== 4'b0000)
      $display("FAIL reset_outs: got %b want 0000", {m_out_valid, m_out_bit, m_out_sof, m_busy}); else n_pass++;
    n_total++; if ({l_out_valid, l_out_bit, l_out_sof, l_busy} !== 4'b0000)
      $display("FAIL reset_outs_lsb: got %b want 0000", {l_out_valid, l_out_bit, l_out_sof, l_busy}); else n_pass++;
    n_total++; if (m_data_ready !== 1'b0)
      $display("FAIL reset_ready: got %b want 0", m_data_ready); else n_pass++;
    data_valid = 1'b0; rst = 1'b0;
    #1;
    n_total++; if (m_data_ready !== 1'b1)
      $display("FAIL ready_after_release: got %b want 1", m_data_ready); else n_pass++;
  endtask

  // Sends nwords (1 or 2) with data_valid held; data_in switches to w1 at bit index sw.
  task automatic run_words(input string name, input logic [7:0] w0, input logic [7:0] w1,
                           input int nwords, input int sw);
    logic [7:0] w;
    int k;
    data_in = w0; data_valid = 1'b1;
    cyc();
    for (int j = 0; j < 8 * nwords; j++) begin
      if (j == sw) data_in = w1;
      if (j == 8 * (nwords - 1)) data_valid = 1'b0;
      w = (j < 8) ? w0 : w1;
      k = j % 8;
      n_total++; if (m_out_valid !== 1'b1 || m_busy !== 1'b1)
        $display("FAIL %s valid b%0d: got %b/%b want 1/1", name, j, m_out_valid, m_busy); else n_pass++;
      n_total++; if (m_out_bit !== w[7-k])
        $display("FAIL %s msb_bit b%0d: got %b want %b", name, j, m_out_bit, w[7-k]); else n_pass++;
      n_total++; if (l_out_bit !== w[k])
        $display("FAIL %s lsb_bit b%0d: got %b want %b", name, j, l_out_bit, w[k]); else n_pass++;
      n_total++; if (m_out_sof !== (k == 0))
        $display("FAIL %s sof b%0d: got %b want %b", name, j, m_out_sof, (k == 0)); else n_pass++;
      n_total++; if (m_data_ready !== (k == 7))
        $display("FAIL %s ready b%0d: got %b want %b", name, j, m_data_ready, (k == 7)); else n_pass++;
      cyc();
    end
    n_total++; if ({m_out_valid, m_out_bit, m_out_sof, l_out_valid} !== 4'b0000)
      $display("FAIL %s end_idle: got %b want 0000", name, {m_out_valid, m_out_bit, m_out_sof, l_out_valid}); else n_pass++;
    n_total++; if (m_data_ready !== 1'b1)
      $display("FAIL %s end_ready: got %b want 1", name, m_data_ready); else n_pass++;
  endtask

  task automatic test_single();
    run_words("single_b6", 8'hB6, 8'h00, 1, 99);
  endtask

  task automatic test_back_to_back();
    run_words("b2b_b6_0f", 8'hB6, 8'h0F, 2, 1);
  endtask

  task automatic test_ignore_busy();
    run_words("ignore_ff", 8'h00, 8'hFF, 2, 2);
  endtask

  task automatic test_reset_mid();
    data_in = 8'hB6; data_valid = 1'b1;
    cyc();
    data_valid = 1'b0;
    cyc(); cyc(); cyc();
    n_total++; if (m_out_bit !== 1'b1 || m_out_valid !== 1'b1)
      $display("FAIL mid_bit3: got %b/%b want 1/1", m_out_bit, m_out_valid); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if ({m_out_valid, m_out_bit, m_out_sof, m_busy, m_data_ready} !== 5'b00000)
      $display("FAIL mid_async_clear: got %b want 00000", {m_out_valid, m_out_bit, m_out_sof, m_busy, m_data_ready}); else n_pass++;
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (m_out_valid !== 1'b0 || l_out_valid !== 1'b0)
        $display("FAIL mid_leftover c%0d: got %b/%b want 0/0", i, m_out_valid, l_out_valid); else n_pass++;
      cyc();
    end
    run_words("post_rst_5a", 8'h5A, 8'h00, 1, 99);
  endtask

  task automatic test_chain();
    logic seq [16] = '{0,1,0,1,1,0,1,1,0,0,1,0,1,1,0,0};
    data_in = 8'h5B; data_valid = 1'b1;
    cyc();
    data_in = 8'h2C;
    for (int j = 0; j < 16; j++) begin
      if (j == 8) data_valid = 1'b0;
      n_total++; if (m_out_valid !== 1'b1 || m_out_bit !== seq[j])
        $display("FAIL chain b%0d: got v%b b%b want v1 b%b", j, m_out_valid, m_out_bit, seq[j]); else n_pass++;
      cyc();
    end
    n_total++; if (m_out_valid !== 1'b0)
      $display("FAIL chain_end: got %b want 0", m_out_valid); else n_pass++;
  endtask

  // Model: queue of accepted words, pos = index of the bit on the wire within the head word.
  task automatic test_random();
    logic [7:0] q [$];
    int pos = 0;
    logic exp_v, exp_m, exp_l, exp_s, exp_r, acc;
    for (int c = 0; c < 400; c++) begin
      data_valid = ($urandom_range(0, 3) != 0);
      data_in = 8'($urandom);
      exp_v = (q.size() > 0);
      exp_m = exp_v ? q[0][7-pos] : 1'b0;
      exp_l = exp_v ? q[0][pos] : 1'b0;
      exp_s = exp_v && (pos == 0);
      exp_r = (q.size() == 0) || (q.size() == 1 && pos == 7);
      n_total++; if ({m_out_valid, m_out_bit, m_out_sof, m_data_ready, m_busy} !== {exp_v, exp_m, exp_s, exp_r, exp_v})
        $display("FAIL rand_msb c%0d: got %b want %b", c, {m_out_valid, m_out_bit, m_out_sof, m_data_ready, m_busy},
                 {exp_v, exp_m, exp_s, exp_r, exp_v}); else n_pass++;
      n_total++; if ({l_out_valid, l_out_bit, l_out_sof, l_data_ready} !== {exp_v, exp_l, exp_s, exp_r})
        $display("FAIL rand_lsb c%0d: got %b want %b", c, {l_out_valid, l_out_bit, l_out_sof, l_data_ready},
                 {exp_v, exp_l, exp_s, exp_r}); else n_pass++;
      acc = data_valid && exp_r;
      cyc();
      if (q.size() > 0) begin
        pos++;
        if (pos == 8) begin
          void'(q.pop_front());
          pos = 0;
        end
      end
      if (acc) q.push_back(data_in);
    end
    data_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_chain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, bits per parallel word; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = MSB shifted out first, 0 = LSB first.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 data_in  input  WIDTH  parallel word to serialize.
REQ-006 data_valid  input  1  data_in holds a word to transfer.
REQ-007 data_ready  output  1  serializer can accept a word this cycle.
REQ-008 out_bit  output  1  serial bit; drives the sequence detector's in_bit.
REQ-009 out_valid  output  1  out_bit carries a valid word bit this cycle.
REQ-010 out_sof  output  1  high on the cycle the first bit of each word is on out_bit.
REQ-011 busy  output  1  high while a word is being shifted (equals out_valid).

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE, SHIFT.
REQ-013 Word transfer SHALL occur on a rising edge where data_valid and data_ready are both 1.
REQ-014 data_ready SHALL be combinational: 1 in IDLE, 1 in SHIFT only when bit_cnt == WIDTH-1, else 0.
REQ-015 On a transfer edge, the block SHALL load data_in into the shift register, set bit_cnt = 0, and enter SHIFT.
REQ-016 out_bit, out_valid, out_sof SHALL be registered; the first bit SHALL appear on the cycle immediately after the transfer edge (latency 1 cycle).
REQ-017 In SHIFT, each rising edge SHALL advance to the next bit and increment bit_cnt; bit order per MSB_FIRST.
REQ-018 out_sof SHALL be 1 only while bit_cnt == 0 in SHIFT; 0 otherwise.
REQ-019 On the edge where bit_cnt == WIDTH-1 with a transfer, the next word's first bit SHALL follow with no gap cycle (back-to-back streaming).
REQ-020 On the edge where bit_cnt == WIDTH-1 without a transfer, FSM SHALL return to IDLE and out_valid SHALL drop to 0.
REQ-021 In IDLE, out_bit SHALL be held at 0 and out_valid, out_sof, busy at 0.
REQ-022 data_valid asserted while data_ready is 0 SHALL be ignored; the current word SHALL NOT be corrupted; data_in changes then SHALL have no effect.
REQ-023 bit_cnt SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-024 While rst is 1, the FSM SHALL be IDLE, bit_cnt and shift register 0, out_bit/out_valid/out_sof/busy 0, data_ready 0.
REQ-025 Reset asserted mid-word SHALL immediately (asynchronously) discard the partial word; no remaining bits SHALL be emitted after release.
REQ-026 After rst deasserts, data_ready SHALL be 1 from the first cycle and a word SHALL be accepted on the first rising edge with data_valid = 1.

Verification
REQ-027 WIDTH=8, MSB_FIRST=1, send 8'hB6 once -> out_bit 1,0,1,1,0,1,1,0 on 8 consecutive cycles; out_sof high only on the first; out_valid then 0.
REQ-028 Back-to-back 8'hB6 then 8'h0F (data_valid held) -> 16 contiguous valid bits 1011_0110_0000_1111; data_ready high only in IDLE and at bit 7; out_sof high on bits 0 and 8.
REQ-029 MSB_FIRST=0, send 8'hB6 -> out_bit 0,1,1,0,1,1,0,1.
REQ-030 data_valid=1 with data_in switched to 8'hFF during bits 2..5 of 8'h00 -> eight 0 bits emitted; 8'hFF accepted only at bit 7 edge and emitted next.
REQ-031 rst pulsed during bit 3 of 8'hB6 -> outputs 0 immediately; after release, no leftover bits; a new 8'h5A emits 0,1,0,1,1,0,1,0.
REQ-032 Chained with seq_detector_moore, stream words whose concatenated bits are 0,1,0,1,1,0,1,1,0,0,1,0,1,1,0,0 -> detected pulses match the detector's response to the same bit sequence driven directly.
